// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory-bus arbiter: the FSM state encoding, the
// default bus timeout, the reset-active level, the pipeline stall level and
// the all-bytes byte-enable pattern used for instruction fetches.
//
// No ports (package).
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

   // Arbiter FSM states. The bus is idle, or owned by the fetch port, or owned
   // by the load/store port.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GNT_IF = 2'b01,
      ST_GNT_LS = 2'b10
   } arb_state_e;

   // Cycles a granted requester may wait for m_ack_i before a bus error.
   localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

   // Level of rst that resets the block.
   localparam logic RST_ENABLE = 1'b1;

   // Levels of stallreq_o toward the pipeline controller.
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Fetches always read a whole word.
   localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter_timer.sv
// -----------------------------------------------------------------------------
// mem_arbiter_timer
// Bus-timeout counter for the arbiter. The count is cleared while 'clear' is
// high, advances by one on each cycle 'enable' is high, and 'expired' reports
// (combinationally) that the count has reached LIMIT. The count saturates at
// LIMIT so it can never wrap back below it.
//
// Parameters:
//   LIMIT    cycles to wait before expiring (1..255)
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active high
//   clear    in   force the count to zero
//   enable   in   advance the count this cycle
//   expired  out  count has reached LIMIT
// -----------------------------------------------------------------------------
module mem_arbiter_timer
   import mem_arbiter_pkg::*;
#(
   parameter logic [7:0] LIMIT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count;

   // The counter. Clear has priority over enable so a grant always starts
   // from zero; once expired the count holds so a stray enable cannot push it
   // past LIMIT and wrap around.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (enable && !expired) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory bus between an instruction-fetch port (read only) and a
// load/store port. A three-state FSM grants the bus to one owner at a time;
// the owner's request is passed straight through to the bus and completes on
// m_ack_i, or on a timeout that returns zero data and pulses bus_err_o. Every
// transaction is followed by one idle cycle before the next grant.
//
// Build option:
//   MEM_ARB_RR_EN  when defined, simultaneous requests in IDLE are granted
//                  to the port that was not served last (round robin);
//                  when undefined, load/store always wins ties.
//
// Parameters:
//   TIMEOUT      cycles allowed for m_ack_i before a bus error (1..255)
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active high
//   if_req_i     in   fetch request, held until if_ack_o
//   if_addr_i    in   fetch address [31:0]
//   if_rdata_o   out  fetch data [31:0], valid with if_ack_o
//   if_ack_o     out  fetch complete, one-cycle pulse
//   ls_req_i     in   load/store request, held until ls_ack_o
//   ls_we_i      in   1 = store, 0 = load
//   ls_sel_i     in   byte enables [3:0]
//   ls_addr_i    in   load/store address [31:0]
//   ls_wdata_i   in   store data [31:0]
//   ls_rdata_o   out  load data [31:0], valid with ls_ack_o
//   ls_ack_o     out  load/store complete, one-cycle pulse
//   m_req_o      out  bus request
//   m_we_o       out  bus write enable
//   m_sel_o      out  bus byte enables [3:0]
//   m_addr_o     out  bus address [31:0]
//   m_wdata_o    out  bus write data [31:0]
//   m_rdata_i    in   bus read data [31:0]
//   m_ack_i      in   bus acknowledge
//   stallreq_o   out  stall the pipeline while any request is outstanding
//   bus_err_o    out  one-cycle pulse on timeout
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ack_o,

   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [3:0]  ls_sel_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   output logic [31:0] ls_rdata_o,
   output logic        ls_ack_o,

   output logic        m_req_o,
   output logic        m_we_o,
   output logic [3:0]  m_sel_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   input  logic [31:0] m_rdata_i,
   input  logic        m_ack_i,

   output logic        stallreq_o,
   output logic        bus_err_o
);

   arb_state_e state;
   arb_state_e state_next;

   logic in_grant;
   logic grant_done;
   logic prefer_ls;
   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   // State register. Reset drops any grant in flight without acknowledging
   // it, so a late m_ack_i simply lands in IDLE and is ignored.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A grant finishes on an ack or a timeout, whichever comes first. The
   // counter is held clear throughout IDLE, which guarantees it starts from
   // zero on the first cycle of every grant, and only advances on grant
   // cycles that did not finish.
   assign in_grant     = (state != ST_IDLE);
   assign grant_done   = in_grant & (m_ack_i | timer_expired);
   assign timer_clear  = ~in_grant;
   assign timer_enable = in_grant & ~grant_done;

   mem_arbiter_timer #(
      .LIMIT   (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

`ifdef MEM_ARB_RR_EN
   logic last_ls;

   // Remember who finished last so a tie in IDLE goes to the other port.
   // Reset leaves the pointer favouring load/store.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         last_ls <= 1'b0;
      end else if (grant_done) begin
         last_ls <= (state == ST_GNT_LS);
      end
   end

   assign prefer_ls = ~last_ls;
`else
   assign prefer_ls = 1'b1;
`endif

   // Next-state and output decode. Everything defaults to zero so that the
   // bus is quiet in IDLE and read data is only non-zero alongside an ack.
   // An ack in the same cycle as the timeout is treated as a normal ack.
   always_comb begin
      state_next = state;
      m_req_o    = 1'b0;
      m_we_o     = 1'b0;
      m_sel_o    = 4'h0;
      m_addr_o   = 32'h0;
      m_wdata_o  = 32'h0;
      if_ack_o   = 1'b0;
      if_rdata_o = 32'h0;
      ls_ack_o   = 1'b0;
      ls_rdata_o = 32'h0;
      bus_err_o  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (ls_req_i && if_req_i) begin
               state_next = prefer_ls ? ST_GNT_LS : ST_GNT_IF;
            end else if (ls_req_i) begin
               state_next = ST_GNT_LS;
            end else if (if_req_i) begin
               state_next = ST_GNT_IF;
            end
         end

         ST_GNT_IF: begin
            m_req_o  = 1'b1;
            m_sel_o  = SEL_ALL;
            m_addr_o = if_addr_i;
            if (m_ack_i) begin
               if_ack_o   = 1'b1;
               if_rdata_o = m_rdata_i;
               state_next = ST_IDLE;
            end else if (timer_expired) begin
               if_ack_o   = 1'b1;
               bus_err_o  = 1'b1;
               state_next = ST_IDLE;
            end
         end

         ST_GNT_LS: begin
            m_req_o   = 1'b1;
            m_we_o    = ls_we_i;
            m_sel_o   = ls_sel_i;
            m_addr_o  = ls_addr_i;
            m_wdata_o = ls_wdata_i;
            if (m_ack_i) begin
               ls_ack_o   = 1'b1;
               ls_rdata_o = m_rdata_i;
               state_next = ST_IDLE;
            end else if (timer_expired) begin
               ls_ack_o   = 1'b1;
               bus_err_o  = 1'b1;
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // A requester stalls the pipeline until the cycle its ack arrives.
   assign stallreq_o = ((if_req_i & ~if_ack_o) | (ls_req_i & ~ls_ack_o)) ? STOP : NO_STOP;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter built with TIMEOUT = 4. Directed
// scenarios cover reset, a single fetch, a tie, timeout, ack on the timeout
// cycle, reset mid-grant, an owner dropping its request and back-to-back
// grants; a randomized run compares every cycle against a transaction-level
// model of the bus. Tie-break expectations follow MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam logic [7:0] TO  = 8'd4;
   localparam int         TOI = 4;
`ifdef MEM_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        ls_req;
   logic        ls_we;
   logic [3:0]  ls_sel;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [31:0] ls_rdata;
   logic        ls_ack;
   logic        m_req;
   logic        m_we;
   logic [3:0]  m_sel;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack;
   logic        stallreq;
   logic        bus_err;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [137:0] exp_v;

   mem_arbiter #(
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_rdata_o (if_rdata),
      .if_ack_o   (if_ack),
      .ls_req_i   (ls_req),
      .ls_we_i    (ls_we),
      .ls_sel_i   (ls_sel),
      .ls_addr_i  (ls_addr),
      .ls_wdata_i (ls_wdata),
      .ls_rdata_o (ls_rdata),
      .ls_ack_o   (ls_ack),
      .m_req_o    (m_req),
      .m_we_o     (m_we),
      .m_sel_o    (m_sel),
      .m_addr_o   (m_addr),
      .m_wdata_o  (m_wdata),
      .m_rdata_i  (m_rdata),
      .m_ack_i    (m_ack),
      .stallreq_o (stallreq),
      .bus_err_o  (bus_err)
   );

   always #5 clk = ~clk;

   // Every DUT output in one vector:
   // {m_req, m_we, m_sel, m_addr, m_wdata, if_ack, if_rdata, ls_ack, ls_rdata, bus_err, stallreq}
   wire [137:0] obs = {m_req, m_we, m_sel, m_addr, m_wdata,
                       if_ack, if_rdata, ls_ack, ls_rdata, bus_err, stallreq};

   function automatic logic [137:0] pack(input logic req, input logic we, input logic [3:0] sel,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         input logic iack, input logic [31:0] ird,
                                         input logic lack, input logic [31:0] lrd,
                                         input logic err, input logic stall);
      return {req, we, sel, addr, wdata, iack, ird, lack, lrd, err, stall};
   endfunction

   // Leaves the bench at a falling edge, arbiter freshly reset and idle.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; m_ack = 1'b0; m_rdata = 32'h0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hA5A5A5A5;
      ls_we = 1'b1; ls_sel = 4'hF; ls_addr = 32'h1234_5678; ls_wdata = 32'h8765_4321;
      if_addr = 32'hCAFE_0000;
      @(negedge clk); #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL reset_idle: got %h expected %h", obs, exp_v); end
      if_req = 1'b1; ls_req = 1'b1; #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL reset_stall: got %h expected %h", obs, exp_v); end
      @(negedge clk); #1;
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL reset_hold: got %h expected %h", obs, exp_v); end
      rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; m_ack = 1'b0;
   endtask

   task automatic test_single_fetch();
      do_reset();
      if_req = 1'b1; if_addr = 32'h100; #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL fetch_wait: got %h expected %h", obs, exp_v); end
      @(negedge clk); #1;
      exp_v = pack(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL fetch_grant: got %h expected %h", obs, exp_v); end
      @(negedge clk);
      m_ack = 1'b1; m_rdata = 32'h0000_0013; #1;
      exp_v = pack(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL fetch_ack: got %h expected %h", obs, exp_v); end
      if_req = 1'b0;
      @(negedge clk);
      m_ack = 1'b0; #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL fetch_idle: got %h expected %h", obs, exp_v); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      if_req = 1'b1; if_addr = 32'h300;
      ls_req = 1'b1; ls_we = 1'b1; ls_sel = 4'hF; ls_addr = 32'h2000; ls_wdata = 32'hDEAD_BEEF;
      @(negedge clk); #1;
      exp_v = pack(1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL simul_ls_grant: got %h expected %h", obs, exp_v); end
      m_ack = 1'b1; m_rdata = 32'h55AA_55AA; #1;
      exp_v = pack(1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 32'h55AA_55AA, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL simul_ls_ack: got %h expected %h", obs, exp_v); end
      ls_req = 1'b0;
      @(negedge clk);
      ls_addr = 32'hBAD0_BAD0; #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL simul_idle_gap: got %h expected %h", obs, exp_v); end
      @(negedge clk);
      m_ack = 1'b0; #1;
      exp_v = pack(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL simul_if_grant: got %h expected %h", obs, exp_v); end
      m_ack = 1'b1; m_rdata = 32'h00C0_FFEE; #1;
      exp_v = pack(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 32'h00C0_FFEE, 1'b0, 32'h0, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL simul_if_ack: got %h expected %h", obs, exp_v); end
      if_req = 1'b0;
      @(negedge clk);
      m_ack = 1'b0; #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL simul_done: got %h expected %h", obs, exp_v); end
   endtask

   task automatic test_timeout();
      do_reset();
      ls_req = 1'b1; ls_we = 1'b0; ls_sel = 4'h3; ls_addr = 32'h4000; ls_wdata = 32'h1234;
      m_ack = 1'b0; m_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      exp_v = pack(1'b1, 1'b0, 4'h3, 32'h4000, 32'h1234, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      for (int k = 0; k < TOI; k++) begin
         #1;
         n_compared++;
         if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL timeout_wait%0d: got %h expected %h", k, obs, exp_v); end
         @(negedge clk);
      end
      #1;
      exp_v = pack(1'b1, 1'b0, 4'h3, 32'h4000, 32'h1234, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL timeout_fire: got %h expected %h", obs, exp_v); end
      ls_req = 1'b0;
      @(negedge clk); #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL timeout_after: got %h expected %h", obs, exp_v); end
   endtask

   task automatic test_ack_on_timeout();
      do_reset();
      if_req = 1'b1; if_addr = 32'h0000_0888; m_ack = 1'b0;
      for (int k = 0; k <= TOI; k++) @(negedge clk);
      m_ack = 1'b1; m_rdata = 32'h0000_0077; #1;
      exp_v = pack(1'b1, 1'b0, 4'hF, 32'h0000_0888, 32'h0, 1'b1, 32'h0000_0077, 1'b0, 32'h0, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL ack_on_timeout: got %h expected %h", obs, exp_v); end
      if_req = 1'b0;
      @(negedge clk);
      m_ack = 1'b0;
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      ls_req = 1'b1; ls_we = 1'b1; ls_sel = 4'hC; ls_addr = 32'h5000; ls_wdata = 32'h0BAD_F00D;
      @(negedge clk); #1;
      exp_v = pack(1'b1, 1'b1, 4'hC, 32'h5000, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL rstmid_grant: got %h expected %h", obs, exp_v); end
      rst = 1'b1;
      @(negedge clk);
      m_ack = 1'b1; m_rdata = 32'h1111_2222; #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL rstmid_reset: got %h expected %h", obs, exp_v); end
      rst = 1'b0; ls_req = 1'b0; #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL rstmid_late_ack: got %h expected %h", obs, exp_v); end
      @(negedge clk); #1;
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL rstmid_idle: got %h expected %h", obs, exp_v); end
      m_ack = 1'b0;
   endtask

   task automatic test_drop_req();
      do_reset();
      if_req = 1'b1; if_addr = 32'h600;
      @(negedge clk);
      if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b1; ls_sel = 4'h5; ls_addr = 32'h7000; ls_wdata = 32'h99; #1;
      exp_v = pack(1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL drop_held: got %h expected %h", obs, exp_v); end
      @(negedge clk); #1;
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL drop_held2: got %h expected %h", obs, exp_v); end
      m_ack = 1'b1; m_rdata = 32'h42; #1;
      exp_v = pack(1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b1, 32'h42, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL drop_ack: got %h expected %h", obs, exp_v); end
      @(negedge clk);
      m_ack = 1'b0; #1;
      exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL drop_idle: got %h expected %h", obs, exp_v); end
      @(negedge clk); #1;
      exp_v = pack(1'b1, 1'b1, 4'h5, 32'h7000, 32'h99, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL drop_ls_grant: got %h expected %h", obs, exp_v); end
      m_ack = 1'b1; m_rdata = 32'h24; #1;
      exp_v = pack(1'b1, 1'b1, 4'h5, 32'h7000, 32'h99, 1'b0, 32'h0, 1'b1, 32'h24, 1'b0, 1'b0);
      n_compared++;
      if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL drop_ls_ack: got %h expected %h", obs, exp_v); end
      ls_req = 1'b0;
      @(negedge clk);
      m_ack = 1'b0;
   endtask

   // Both ports request continuously and the memory acks at once; record the
   // order in which the ports are served.
   task automatic test_back_to_back();
      int seq[6];
      int got;
      int want;
      do_reset();
      if_req = 1'b1; if_addr = 32'h500;
      ls_req = 1'b1; ls_we = 1'b0; ls_sel = 4'hF; ls_addr = 32'h5500; ls_wdata = 32'h0;
      got = 0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(negedge clk);
         m_ack = 1'b0; #1;
         if (m_req) begin
            m_ack = 1'b1; m_rdata = 32'(cyc); #1;
            if (ls_ack) seq[got] = 2;
            else if (if_ack) seq[got] = 1;
            else seq[got] = 0;
            got++;
         end
      end
      @(negedge clk);
      m_ack = 1'b0; if_req = 1'b0; ls_req = 1'b0;
      n_compared++;
      if (got != 6) begin n_mismatched++; $display("[TB] FAIL b2b_count: got %0d grants expected 6", got); end
      for (int i = 0; i < got; i++) begin
         want = (RR_MODE && (i % 2 == 1)) ? 1 : 2;
         n_compared++;
         if (seq[i] != want) begin n_mismatched++; $display("[TB] FAIL b2b_owner%0d: got %0d expected %0d (1=IF 2=LS)", i, seq[i], want); end
      end
   endtask

   // Random requesters and a memory with random latency (sometimes silent),
   // checked every cycle against a transaction-level view of the bus: who
   // owns it, how long the owner has waited, and what the memory answered.
   task automatic test_random(input int cycles);
      int          owner;
      int          age;
      int          lat;
      bit          last_ls;
      bit          ack_now;
      bit          to_now;
      bit          done;
      logic        stall;
      logic [31:0] mem_data;
      do_reset();
      owner = 0; age = 0; lat = 0; last_ls = 1'b0; mem_data = 32'h0;
      for (int c = 0; c < cycles; c++) begin
         if (owner != 0 && age == lat) begin
            m_ack = 1'b1; m_rdata = mem_data;
         end else begin
            m_ack = (owner == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            m_rdata = $urandom;
         end
         #1;
         ack_now = (owner != 0) && (age == lat);
         to_now  = (owner != 0) && !ack_now && (age == TOI);
         done    = ack_now || to_now;
         stall   = (if_req && !(owner == 1 && done)) || (ls_req && !(owner == 2 && done));
         if (owner == 1)
            exp_v = pack(1'b1, 1'b0, 4'hF, if_addr, 32'h0, done, ack_now ? mem_data : 32'h0,
                         1'b0, 32'h0, to_now, stall);
         else if (owner == 2)
            exp_v = pack(1'b1, ls_we, ls_sel, ls_addr, ls_wdata, 1'b0, 32'h0,
                         done, ack_now ? mem_data : 32'h0, to_now, stall);
         else
            exp_v = pack(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, stall);
         n_compared++;
         if (obs !== exp_v) begin n_mismatched++; $display("[TB] FAIL random_cycle%0d: got %h expected %h", c, obs, exp_v); end

         if (owner == 1 && done) if_req = 1'b0;
         else if (!if_req) begin
            if_addr = $urandom;
            if ($urandom_range(0, 2) == 0) if_req = 1'b1;
         end
         if (owner == 2 && done) ls_req = 1'b0;
         else if (!ls_req) begin
            ls_addr = $urandom; ls_wdata = $urandom; ls_sel = 4'($urandom); ls_we = 1'($urandom);
            if ($urandom_range(0, 2) == 0) ls_req = 1'b1;
         end

         if (owner == 0) begin
            if (ls_req && if_req) owner = (RR_MODE && last_ls) ? 1 : 2;
            else if (ls_req) owner = 2;
            else if (if_req) owner = 1;
            age = 0; lat = $urandom_range(0, TOI + 1); mem_data = $urandom;
         end else if (done) begin
            last_ls = (owner == 2);
            owner = 0;
         end else begin
            age++;
         end
         @(negedge clk);
      end
      if_req = 1'b0; ls_req = 1'b0; m_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0;
      ls_sel = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0; m_ack = 1'b0; m_rdata = 32'h0;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_timeout();
      test_ack_on_timeout();
      test_reset_mid_grant();
      test_drop_req();
      test_back_to_back();
      test_random(800);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
